// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM states,
// instruction word width and the default sequential PC step.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned PC_STEP_DEF = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. clear drops the valid bit, load captures a new
// fetch, hold keeps the current contents; otherwise the held entry is
// treated as consumed and valid drops. Payload fields keep their last value
// after valid drops.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               hold,
    input  logic               clear,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [XLEN-1:0]    d_pc,
    input  logic [XLEN-1:0]    d_pc_plus4,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4
);

    // Register update: clear beats load, load beats hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= d_instr;
            pc       <= d_pc;
            pc_plus4 <= d_pc_plus4;
        end else if (!hold) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests
// to a variable-latency imem, fills the IF/ID register and steers the PC on
// branch / jump / register-jump redirects and flushes.
// Optional macro IF_JR_EN adds the jr / jr_target register-jump ports.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = PC_STEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               id_stall,
    input  logic               br_taken,
    input  logic [15:0]        br_offset,
    input  logic               jmp,
    input  logic [25:0]        jmp_index,
`ifdef IF_JR_EN
    input  logic               jr,
    input  logic [XLEN-1:0]    jr_target,
`endif
    input  logic               flush,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [XLEN-1:0]    if_pc,
    output logic [XLEN-1:0]    if_pc_plus4
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jmp_target;
    logic [XLEN-1:0] jr_addr;
    logic [XLEN-1:0] target;
    logic            discard_q;
    logic            jr_req;
    logic            redirect;
    logic            rsp_take;
    logic            ifid_clear;

    // Redirect decode and target selection (jr > jmp > br_taken).
    always_comb begin
`ifdef IF_JR_EN
        jr_req  = jr;
        jr_addr = jr_target & ~XLEN'(3);
`else
        jr_req  = 1'b0;
        jr_addr = '0;
`endif
        redirect   = jr_req | jmp | br_taken;
        br_target  = if_pc_plus4 + {{(XLEN-18){br_offset[15]}}, br_offset, 2'b00};
        jmp_target = {if_pc_plus4[XLEN-1:28], jmp_index, 2'b00};
        if (jr_req) begin
            target = jr_addr;
        end else if (jmp) begin
            target = jmp_target;
        end else begin
            target = br_target;
        end
        pc_seq     = pc_q + XLEN'(PC_STEP);
        ifid_clear = redirect | flush;
    end

    // Fetch FSM next state and request strobe. Only issue when IF/ID is
    // free or draining this cycle, so the response always has a slot.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        imem_addr = pc_q;
        rsp_take  = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                imem_req = ~redirect & (~if_valid | ~id_stall);
                if (imem_req) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d  = ST_REQ;
                    rsp_take = ~discard_q & ~redirect & ~flush;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, PC and discard tracking. pc only advances when a fetch lands,
    // so a flushed fetch is retried from the same pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                pc_q <= target;
            end else if (rsp_take) begin
                pc_q <= pc_seq;
            end
            if (state_q == ST_WAIT) begin
                if (imem_rvalid) begin
                    discard_q <= 1'b0;
                end else if (ifid_clear) begin
                    discard_q <= 1'b1;
                end
            end
        end
    end

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (rsp_take),
        .hold       (id_stall),
        .clear      (ifid_clear),
        .d_instr    (imem_rdata),
        .d_pc       (pc_q),
        .d_pc_plus4 (pc_seq),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc),
        .pc_plus4   (if_pc_plus4)
    );

endmodule
